// File: rtl/spi_channel_deframer.sv
// SPI mode-0 slave deframer: header word selects a channel (ctl),
// following words are presented on data with a one-clk data_valid strobe.
module spi_channel_deframer #(
    parameter int BUS_WIDTH   = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 spi_sclk,
    input  logic                 spi_mosi,
    input  logic                 spi_cs_n,
    output logic [1:0]           ctl,
    output logic [BUS_WIDTH-1:0] data,
    output logic                 data_valid,
    output logic                 frame_active,
    output logic                 frame_err
);

    localparam int CW = $clog2(BUS_WIDTH);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        HEADER  = 2'd1,
        PAYLOAD = 2'd2,
        DISCARD = 2'd3
    } state_t;

    logic [SYNC_STAGES-1:0] sclk_sync_r;
    logic [SYNC_STAGES-1:0] mosi_sync_r;
    logic [SYNC_STAGES-1:0] cs_sync_r;
    logic [SYNC_STAGES:0]   arm_r;
    logic                   sclk_d_r;
    logic                   mosi_d_r;
    logic                   cs_d_r;
    logic                   rise_r;
    logic                   cs_fall_r;
    logic                   cs_rise_r;

    state_t                 state_r, state_n;
    logic [CW-1:0]          cnt_r, cnt_n;
    logic [BUS_WIDTH-1:0]   shift_r, shift_n;
    logic [1:0]             ctl_r, ctl_n;
    logic [BUS_WIDTH-1:0]   data_r, data_n;
    logic                   valid_r, valid_n;
    logic                   err_r, err_n;
    logic                   active_r;
    logic [BUS_WIDTH-1:0]   word_s;
    logic                   done_s;

    // Input synchronisers and registered edge detection.
    // arm_r blocks CS edges until the chains have flushed after reset, so a
    // CS pin already low at reset release is not mistaken for a new frame.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sclk_sync_r <= {SYNC_STAGES{1'b0}};
            mosi_sync_r <= {SYNC_STAGES{1'b0}};
            cs_sync_r   <= {SYNC_STAGES{1'b1}};
            arm_r       <= {(SYNC_STAGES+1){1'b0}};
            sclk_d_r    <= 1'b0;
            mosi_d_r    <= 1'b0;
            cs_d_r      <= 1'b1;
            rise_r      <= 1'b0;
            cs_fall_r   <= 1'b0;
            cs_rise_r   <= 1'b0;
        end else begin
            sclk_sync_r <= {sclk_sync_r[SYNC_STAGES-2:0], spi_sclk};
            mosi_sync_r <= {mosi_sync_r[SYNC_STAGES-2:0], spi_mosi};
            cs_sync_r   <= {cs_sync_r[SYNC_STAGES-2:0], spi_cs_n};
            arm_r       <= {arm_r[SYNC_STAGES-1:0], 1'b1};
            sclk_d_r    <= sclk_sync_r[SYNC_STAGES-1];
            mosi_d_r    <= mosi_sync_r[SYNC_STAGES-1];
            cs_d_r      <= cs_sync_r[SYNC_STAGES-1];
            rise_r      <= sclk_sync_r[SYNC_STAGES-1] & ~sclk_d_r;
            cs_fall_r   <= arm_r[SYNC_STAGES] & cs_d_r & ~cs_sync_r[SYNC_STAGES-1];
            cs_rise_r   <= arm_r[SYNC_STAGES] & ~cs_d_r & cs_sync_r[SYNC_STAGES-1];
        end
    end

    assign word_s = {shift_r[BUS_WIDTH-2:0], mosi_d_r};
    assign done_s = rise_r && (cnt_r == CW'(BUS_WIDTH-1));

    // Frame state machine: next state, shifter and output values.
    always_comb begin
        state_n = state_r;
        cnt_n   = cnt_r;
        shift_n = shift_r;
        ctl_n   = ctl_r;
        data_n  = data_r;
        valid_n = 1'b0;
        err_n   = 1'b0;
        case (state_r)
            IDLE: begin
                if (cs_fall_r) begin
                    state_n = HEADER;
                    cnt_n   = {CW{1'b0}};
                    shift_n = {BUS_WIDTH{1'b0}};
                end else begin
                    state_n = IDLE;
                end
            end
            HEADER, PAYLOAD, DISCARD: begin
                if (rise_r) begin
                    shift_n = word_s;
                    if (done_s) begin
                        cnt_n = {CW{1'b0}};
                    end else begin
                        cnt_n = cnt_r + CW'(1);
                    end
                end else begin
                    shift_n = shift_r;
                end
                if (done_s) begin
                    if (state_r == HEADER) begin
                        if (word_s[BUS_WIDTH-1]) begin
                            ctl_n   = word_s[1:0];
                            state_n = PAYLOAD;
                        end else begin
                            err_n   = 1'b1;
                            state_n = DISCARD;
                        end
                    end else if (state_r == PAYLOAD) begin
                        data_n  = word_s;
                        valid_n = 1'b1;
                    end else begin
                        state_n = DISCARD;
                    end
                end else begin
                    state_n = state_r;
                end
                // A word completing on the same cycle as CS rise is kept; only a
                // leftover partial word is flagged.
                if (cs_rise_r) begin
                    err_n   = err_n | (cnt_n != {CW{1'b0}});
                    state_n = IDLE;
                    cnt_n   = {CW{1'b0}};
                    shift_n = {BUS_WIDTH{1'b0}};
                end else begin
                    state_n = state_n;
                end
            end
            default: begin
                state_n = IDLE;
                cnt_n   = {CW{1'b0}};
                shift_n = {BUS_WIDTH{1'b0}};
            end
        endcase
    end

    // State and registered outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r  <= IDLE;
            cnt_r    <= {CW{1'b0}};
            shift_r  <= {BUS_WIDTH{1'b0}};
            ctl_r    <= 2'b00;
            data_r   <= {BUS_WIDTH{1'b0}};
            valid_r  <= 1'b0;
            err_r    <= 1'b0;
            active_r <= 1'b0;
        end else begin
            state_r  <= state_n;
            cnt_r    <= cnt_n;
            shift_r  <= shift_n;
            ctl_r    <= ctl_n;
            data_r   <= data_n;
            valid_r  <= valid_n;
            err_r    <= err_n;
            active_r <= (state_n != IDLE);
        end
    end

    assign ctl          = ctl_r;
    assign data         = data_r;
    assign data_valid   = valid_r;
    assign frame_err    = err_r;
    assign frame_active = active_r;

endmodule
